// File: rtl/mem_port_pkg.sv
// Shared types and default widths for the memory port master.
// Holds the FSM state enum and a helper that marks the states which own the memory bus.
package mem_port_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_FETCH = 3'd2,
    RD_DRIVE = 3'd3,
    RESP     = 3'd4
  } state_e;

  function automatic logic is_bus_state(state_e s);
    return (s == WRITE) || (s == RD_FETCH) || (s == RD_DRIVE);
  endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// Request/response handshake and memory control signals for mem_port_master.
// The bidirectional data bus is kept outside the interface as a plain inout port.
interface mem_port_master_if
  import mem_port_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_re;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_cs, mem_we, mem_re
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_cs, mem_we, mem_re
  );

endinterface

// File: rtl/mem_port_iobuf.sv
// Tristate pad driver for the shared memory data bus.
// The pad is released to Z whenever the output enable is low.
module mem_port_iobuf #(
  parameter int WIDTH = 8
) (
  input  logic             oe_i,
  input  logic [WIDTH-1:0] out_i,
  output logic [WIDTH-1:0] in_o,
  inout  wire  [WIDTH-1:0] pad_io
);

  assign pad_io = oe_i ? out_i : {WIDTH{1'bz}};
  assign in_o   = pad_io;

endmodule

// File: rtl/mem_port_master.sv
// Single-outstanding memory port master: one request at a time over a shared tristate bus.
// Define MEM_PORT_MASTER_WRITE_ACK_EN to make writes produce a response pulse as well.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_master_if.master bus,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              started_q;
  logic [DATA_W-1:0] busIn;
  logic              driveEn;
  logic              handshake;

  // started_q keeps req_ready low until the first edge after reset release.
  assign handshake = (state_q == IDLE) && started_q && bus.req_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = bus.req_write ? WRITE : RD_FETCH;
        end
      end
      WRITE: begin
`ifdef MEM_PORT_MASTER_WRITE_ACK_EN
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      RD_FETCH: state_d = RD_DRIVE;
      RD_DRIVE: begin
        rdata_d = busIn;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      started_q <= 1'b1;
    end
  end

  // Memory controls decode registered state only, never the incoming request.
  assign driveEn       = (state_q == WRITE);
  assign bus.mem_cs    = is_bus_state(state_q);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_re    = (state_q == RD_DRIVE);
  assign bus.mem_addr  = addr_q;
  assign bus.req_ready = (state_q == IDLE) && started_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;

  mem_port_iobuf #(
    .WIDTH(DATA_W)
  ) u_iobuf (
    .oe_i   (driveEn),
    .out_i  (wdata_q),
    .in_o   (busIn),
    .pad_io (mem_data)
  );

endmodule

// File: tb/tb_mem_port_master.sv
// Directed plus randomized checks of mem_port_master against a byte-array memory model.
// A simple synchronous slave memory sits on the shared bus and answers reads when mem_re is high.
module tb_mem_port_master;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  wire  [DW-1:0] memData;
  logic [DW-1:0] slaveMem [16] = '{default: 8'h00};
  logic [DW-1:0] slaveLatch = 8'h00;
  logic [DW-1:0] refMem [16];
  logic [DW-1:0] refRdata;
  int            assertCount = 0;
  int            failCount   = 0;

  mem_port_master_if #(.DATA_W(DW), .ADDR_W(AW)) busIf ();

  mem_port_master #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (busIf.master),
    .mem_data (memData)
  );

  always #5 clk = ~clk;

  // Slave: writes on cs&we, latches the word on a cs-only cycle, drives it while re is high.
  assign memData = busIf.mem_re ? slaveLatch : {DW{1'bz}};

  always @(posedge clk) begin
    if (busIf.mem_cs) begin
      if (busIf.mem_we)
        slaveMem[busIf.mem_addr] <= memData;
      else if (!busIf.mem_re)
        slaveLatch <= slaveMem[busIf.mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers a request at a negedge, waits (bounded) for acceptance, returns in the first cycle after it.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input bit hold);
    int waited;
    busIf.req_valid = 1'b1;
    busIf.req_write = wr;
    busIf.req_addr  = a;
    busIf.req_wdata = d;
    waited = 0;
    while (!busIf.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) busIf.req_valid = 1'b0;
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b1, a, d, 1'b0);
    checkOutput("wr_cs",    32'(busIf.mem_cs), 32'd1);
    checkOutput("wr_we",    32'(busIf.mem_we), 32'd1);
    checkOutput("wr_re",    32'(busIf.mem_re), 32'd0);
    checkOutput("wr_bus",   32'(memData), 32'(d));
    checkOutput("wr_addr",  32'(busIf.mem_addr), 32'(a));
    checkOutput("wr_ready", 32'(busIf.req_ready), 32'd0);
    checkOutput("wr_nopulse", 32'(busIf.rsp_valid), 32'd0);
    refMem[a] = d;
    @(negedge clk);
    checkOutput("wr_mem", 32'(slaveMem[a]), 32'(d));
`ifdef MEM_PORT_MASTER_WRITE_ACK_EN
    checkOutput("wr_ack",   32'(busIf.rsp_valid), 32'd1);
    checkOutput("wr_rdata", 32'(busIf.rsp_rdata), 32'(refRdata));
    checkOutput("wr_ackcs", 32'(busIf.mem_cs), 32'd0);
    @(negedge clk);
`else
    checkOutput("wr_noack", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("wr_rdata", 32'(busIf.rsp_rdata), 32'(refRdata));
`endif
    checkOutput("wr_idle_ready", 32'(busIf.req_ready), 32'd1);
    checkOutput("wr_idle_cs",    32'(busIf.mem_cs), 32'd0);
  endtask

  task automatic doRead(input logic [AW-1:0] a, input bit hold);
    applyStimulus(1'b0, a, 8'h00, hold);
    checkOutput("rd_fetch_cs",  32'(busIf.mem_cs), 32'd1);
    checkOutput("rd_fetch_we",  32'(busIf.mem_we), 32'd0);
    checkOutput("rd_fetch_re",  32'(busIf.mem_re), 32'd0);
    checkOutput("rd_addr",      32'(busIf.mem_addr), 32'(a));
    checkOutput("rd_fetch_rdy", 32'(busIf.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("rd_drive_cs",  32'(busIf.mem_cs), 32'd1);
    checkOutput("rd_drive_re",  32'(busIf.mem_re), 32'd1);
    checkOutput("rd_drive_we",  32'(busIf.mem_we), 32'd0);
    checkOutput("rd_drive_vld", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("rd_drive_rdy", 32'(busIf.req_ready), 32'd0);
    @(negedge clk);
    refRdata = refMem[a];
    checkOutput("rd_rsp_valid", 32'(busIf.rsp_valid), 32'd1);
    checkOutput("rd_rsp_rdata", 32'(busIf.rsp_rdata), 32'(refRdata));
    checkOutput("rd_rsp_cs",    32'(busIf.mem_cs), 32'd0);
    checkOutput("rd_rsp_rdy",   32'(busIf.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("rd_idle_ready", 32'(busIf.req_ready), 32'd1);
    checkOutput("rd_idle_vld",   32'(busIf.rsp_valid), 32'd0);
    checkOutput("rd_idle_rdata", 32'(busIf.rsp_rdata), 32'(refRdata));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
    refRdata        = 8'h00;
    rst_n           = 1'b0;
    busIf.req_valid = 1'b0;
    busIf.req_write = 1'b0;
    busIf.req_addr  = '0;
    busIf.req_wdata = '0;

    #1;
    checkOutput("rst_ready", 32'(busIf.req_ready), 32'd0);
    checkOutput("rst_cs",    32'(busIf.mem_cs), 32'd0);
    checkOutput("rst_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("rst_rdata", 32'(busIf.rsp_rdata), 32'd0);
    checkOutput("rst_addr",  32'(busIf.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_low", 32'(busIf.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("rel_ready_high", 32'(busIf.req_ready), 32'd1);

    $display("[TB] directed write/read at 0x3");
    doWrite(4'h3, 8'hA5);
    doRead(4'h3, 1'b0);

    $display("[TB] address extremes");
    doWrite(4'h0, 8'h11);
    doWrite(4'hF, 8'hFF);
    doRead(4'h0, 1'b0);
    doRead(4'hF, 1'b0);

    // req_valid stays high through a read; the repeat must wait for IDLE.
    $display("[TB] held req_valid");
    doRead(4'hF, 1'b1);
    @(negedge clk);
    busIf.req_valid = 1'b0;
    checkOutput("hold_second_cs",   32'(busIf.mem_cs), 32'd1);
    checkOutput("hold_second_re",   32'(busIf.mem_re), 32'd0);
    checkOutput("hold_second_addr", 32'(busIf.mem_addr), 32'hF);
    @(negedge clk);
    checkOutput("hold_second_drv",  32'(busIf.mem_re), 32'd1);
    @(negedge clk);
    checkOutput("hold_second_vld",  32'(busIf.rsp_valid), 32'd1);
    checkOutput("hold_second_data", 32'(busIf.rsp_rdata), 32'hFF);
    @(negedge clk);
    checkOutput("hold_done_ready",  32'(busIf.req_ready), 32'd1);

    $display("[TB] reset during RD_DRIVE");
    applyStimulus(1'b0, 4'h3, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("mid_drive_re", 32'(busIf.mem_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cs",    32'(busIf.mem_cs), 32'd0);
    checkOutput("mid_rst_we",    32'(busIf.mem_we), 32'd0);
    checkOutput("mid_rst_re",    32'(busIf.mem_re), 32'd0);
    checkOutput("mid_rst_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("mid_rst_rdata", 32'(busIf.rsp_rdata), 32'd0);
    checkOutput("mid_rst_ready", 32'(busIf.req_ready), 32'd0);
    checkOutput("mid_rst_addr",  32'(busIf.mem_addr), 32'd0);
    @(negedge clk);
    checkOutput("mid_rst_novalid", 32'(busIf.rsp_valid), 32'd0);
    rst_n    = 1'b1;
    refRdata = 8'h00;
    #1;
    checkOutput("mid_rel_ready_low", 32'(busIf.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("mid_rel_ready",   32'(busIf.req_ready), 32'd1);
    checkOutput("mid_rel_novalid", 32'(busIf.rsp_valid), 32'd0);

    $display("[TB] write 0x5A, response depends on write-ack build");
    doWrite(4'h5, 8'h5A);
    doRead(4'h5, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      ra = AW'($urandom_range(0, 15));
      rd = DW'($urandom);
      if ($urandom_range(0, 1) == 1) doWrite(ra, rd);
      else doRead(ra, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
